// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram_like memory port between the instruction-fetch
// master and the MEM-stage data master. Address phases are granted by priority
// (data over inst), a grant stays locked until the slave accepts it, and the owner
// of every accepted transaction is queued so that in-order data_ok responses are
// returned to the master that issued them.
//
// Optional build macro: ARB_RR_EN
//   defined   -> round-robin between the masters when both request in IDLE
//   undefined -> fixed data-over-inst priority, no round-robin register
module sram_like_arbiter #(
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    // A single-entry queue still needs a one-bit pointer to index it.
    localparam int               PTR_W    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);

    state_t           state;
    state_t           state_nxt;
    owner_t           lock_owner;
    owner_t           lock_owner_nxt;
    owner_t           idle_winner;
    owner_t           sel_owner;
    owner_t           head;

    owner_t           owner_fifo [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             sel_req;
    logic             full;
    logic             req_ok;
    logic             push;
    logic             pop;

`ifdef ARB_RR_EN
    owner_t           rr_ptr;
`endif

    assign full = (count == FULL_CNT);
    assign head = owner_fifo[rd_ptr];

`ifdef ARB_RR_EN
    // Pick the IDLE winner: a lone requester wins, a tie goes to the rr pointer.
    always_comb begin
        idle_winner = OWN_INST;
        if (data_req && inst_req) begin
            idle_winner = rr_ptr;
        end else if (data_req) begin
            idle_winner = OWN_DATA;
        end else begin
            idle_winner = OWN_INST;
        end
    end
`else
    // Pick the IDLE winner: data always beats inst.
    always_comb begin
        idle_winner = OWN_INST;
        if (data_req) begin
            idle_winner = OWN_DATA;
        end
    end
`endif

    // The port belongs to the fresh winner in IDLE and to the locked owner in LOCK.
    always_comb begin
        sel_owner = idle_winner;
        if (state == ST_LOCK) begin
            sel_owner = lock_owner;
        end
    end

    // Steer the selected master onto the shared port; requests are held off while
    // the owner queue is full and while reset is asserted.
    always_comb begin
        sel_req   = inst_req;
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
        if (sel_owner == OWN_DATA) begin
            sel_req   = data_req;
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end
        req_ok = sel_req & ~full & resetn;
    end

    // Handshake decode: a push is an accepted address, a pop is a response that
    // has a queued owner to go to (stray responses on an empty queue are dropped).
    always_comb begin
        mem_req      = req_ok;
        push         = req_ok & mem_addr_ok;
        pop          = mem_data_ok & (count != '0) & resetn;
        inst_addr_ok = push & (sel_owner == OWN_INST);
        data_addr_ok = push & (sel_owner == OWN_DATA);
        inst_data_ok = pop & (head == OWN_INST);
        data_data_ok = pop & (head == OWN_DATA);
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    // Next-state logic: an unaccepted request locks its owner until addr_ok,
    // and a locked owner that withdraws its request releases the port.
    always_comb begin
        state_nxt      = state;
        lock_owner_nxt = lock_owner;
        case (state)
            ST_IDLE: begin
                if (req_ok && !mem_addr_ok) begin
                    lock_owner_nxt = idle_winner;
                    state_nxt      = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (!sel_req) begin
                    state_nxt = ST_IDLE;
                end else if (push) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and lock owner.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            lock_owner <= OWN_INST;
        end else begin
            state      <= state_nxt;
            lock_owner <= lock_owner_nxt;
        end
    end

    // Owner queue pointers and occupancy; a same-cycle push and pop cancel out.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Owner queue storage; entries are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            owner_fifo[wr_ptr] <= sel_owner;
        end
    end

`ifdef ARB_RR_EN
    // After every accepted address the master that did not win gets the next tie.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr <= OWN_DATA;
        end else if (push) begin
            rr_ptr <= (sel_owner == OWN_DATA) ? OWN_INST : OWN_DATA;
        end
    end
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed bench for sram_like_arbiter. The bench plays the
// memory slave; the owner of each accepted address is pushed to a scoreboard queue
// and popped when the bench returns the matching mem_data_ok.
module tb_sram_like_arbiter;

`ifdef ARB_RR_EN
    localparam logic RR_MODE = 1'b1;
`else
    localparam logic RR_MODE = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    sram_like_arbiter #(
        .MAX_OUTST (2),
        .CNT_W     (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of master and slave inputs, then let the combinational paths settle.
    task automatic applyStimulus(input logic i_req, input logic [31:0] i_addr,
                                 input logic d_req, input logic d_wr,
                                 input logic [31:0] d_addr, input logic [31:0] d_wdata,
                                 input logic a_ok, input logic r_ok,
                                 input logic [31:0] r_data);
        inst_req    = i_req;
        inst_wr     = 1'b0;
        inst_size   = 2'b10;
        inst_addr   = i_addr;
        inst_wdata  = 32'h0;
        data_req    = d_req;
        data_wr     = d_wr;
        data_size   = 2'b01;
        data_addr   = d_addr;
        data_wdata  = d_wdata;
        mem_addr_ok = a_ok;
        mem_data_ok = r_ok;
        mem_rdata   = r_data;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expect the selected master's address to be accepted this cycle.
    task automatic checkGrant(input string tag, input logic exp_data, input logic [31:0] exp_addr);
        checkOutput({tag, "_mem_req"}, {31'b0, mem_req}, 32'd1);
        checkOutput({tag, "_mem_addr"}, mem_addr, exp_addr);
        checkOutput({tag, "_inst_addr_ok"}, {31'b0, inst_addr_ok}, {31'b0, ~exp_data});
        checkOutput({tag, "_data_addr_ok"}, {31'b0, data_addr_ok}, {31'b0, exp_data});
        exp_q.push_back(exp_data);
    endtask

    // Expect no address acceptance, with the given shared request level.
    task automatic checkWait(input string tag, input logic exp_req);
        checkOutput({tag, "_mem_req"}, {31'b0, mem_req}, {31'b0, exp_req});
        checkOutput({tag, "_inst_addr_ok"}, {31'b0, inst_addr_ok}, 32'd0);
        checkOutput({tag, "_data_addr_ok"}, {31'b0, data_addr_ok}, 32'd0);
    endtask

    task automatic checkSilent(input string tag);
        checkOutput({tag, "_inst_data_ok"}, {31'b0, inst_data_ok}, 32'd0);
        checkOutput({tag, "_data_data_ok"}, {31'b0, data_data_ok}, 32'd0);
    endtask

    // Pop the scoreboard and check the response goes to the recorded owner.
    task automatic checkResponse(input string tag, input logic [31:0] exp_rdata);
        logic exp_data;
        checkOutput({tag, "_queue_nonempty"}, {31'b0, (exp_q.size() > 0)}, 32'd1);
        if (exp_q.size() > 0) begin
            exp_data = exp_q.pop_front();
            checkOutput({tag, "_inst_data_ok"}, {31'b0, inst_data_ok}, {31'b0, ~exp_data});
            checkOutput({tag, "_data_data_ok"}, {31'b0, data_data_ok}, {31'b0, exp_data});
            checkOutput({tag, "_inst_rdata"}, inst_rdata, exp_rdata);
            checkOutput({tag, "_data_rdata"}, data_rdata, exp_rdata);
        end
    endtask

    // Directed sequence: reset, single read, contention, lock, full, reset flush, arbitration.
    initial begin
        // Reset with every input active: nothing may leak out.
        resetn = 1'b0;
        applyStimulus(1'b1, 32'hBFC00000, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 1'b1, 32'hFFFF0000);
        checkWait("rst0", 1'b0);
        checkSilent("rst0");
        tick();
        tick();
        checkWait("rst1", 1'b0);
        checkSilent("rst1");
        resetn = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF0001);
        checkWait("rst_rel", 1'b0);
        checkSilent("rst_rel");
        tick();

        $display("[TB] single read");
        applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkWait("t1_wait", 1'b1);
        checkOutput("t1_wait_addr", mem_addr, 32'hBFC00000);
        tick();
        applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkGrant("t1_grant", 1'b0, 32'hBFC00000);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkWait("t1_idle", 1'b0);
        checkSilent("t1_idle");
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3C080001);
        checkResponse("t1_resp", 32'h3C080001);
        tick();

        $display("[TB] contention");
        applyStimulus(1'b1, 32'hBFC00004, 1'b1, 1'b1, 32'h00001000, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
        checkGrant("t2_data", 1'b1, 32'h00001000);
        checkOutput("t2_data_wr", {31'b0, mem_wr}, 32'd1);
        checkOutput("t2_data_wdata", mem_wdata, 32'hDEADBEEF);
        checkOutput("t2_data_size", {30'b0, mem_size}, 32'd1);
        tick();
        applyStimulus(1'b1, 32'hBFC00004, 1'b0, 1'b0, 32'h00001000, 32'h0, 1'b1, 1'b0, 32'h0);
        checkGrant("t2_inst", 1'b0, 32'hBFC00004);
        checkOutput("t2_inst_wr", {31'b0, mem_wr}, 32'd0);
        checkOutput("t2_inst_size", {30'b0, mem_size}, 32'd2);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h11111111);
        checkResponse("t2_resp0", 32'h11111111);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h22222222);
        checkResponse("t2_resp1", 32'h22222222);
        tick();

        $display("[TB] lock");
        applyStimulus(1'b1, 32'hBFC00010, 1'b0, 1'b0, 32'h2000, 32'h0, 1'b0, 1'b0, 32'h0);
        checkWait("t3_c1", 1'b1);
        checkOutput("t3_c1_addr", mem_addr, 32'hBFC00010);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'hBFC00010, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, 1'b0, 32'h0);
            checkWait("t3_locked", 1'b1);
            checkOutput("t3_locked_addr", mem_addr, 32'hBFC00010);
            tick();
        end
        applyStimulus(1'b1, 32'hBFC00010, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b1, 1'b0, 32'h0);
        checkGrant("t3_inst", 1'b0, 32'hBFC00010);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b1, 1'b0, 32'h0);
        checkGrant("t3_data", 1'b1, 32'h2000);
        tick();

        $display("[TB] full");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'hBFC00020, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
            checkWait("t4_full", 1'b0);
            tick();
        end
        applyStimulus(1'b1, 32'hBFC00020, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hAAAA0001);
        checkWait("t4_full_pop", 1'b0);
        checkResponse("t4_resp0", 32'hAAAA0001);
        tick();
        applyStimulus(1'b1, 32'hBFC00020, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkGrant("t4_resume", 1'b0, 32'hBFC00020);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hAAAA0002);
        checkResponse("t4_resp1", 32'hAAAA0002);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hAAAA0003);
        checkResponse("t4_resp2", 32'hAAAA0003);
        tick();

        $display("[TB] reset with outstanding transactions");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'hBFC00030, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
            checkGrant("t5_fill", 1'b0, 32'hBFC00030);
            tick();
        end
        resetn = 1'b0;
        applyStimulus(1'b1, 32'hBFC00030, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hBAD00000);
        checkWait("t5_in_reset", 1'b0);
        checkSilent("t5_in_reset");
        tick();
        exp_q.delete();
        resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hBAD00001);
            checkSilent("t5_stray");
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'hBFC00040, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
            checkGrant("t5_refill", 1'b0, 32'hBFC00040);
            tick();
        end
        applyStimulus(1'b1, 32'hBFC00040, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkWait("t5_full_again", 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCCCC0000 + i);
            checkResponse("t5_drain", 32'hCCCC0000 + i);
            tick();
        end

        $display("[TB] continuous contention");
        for (int pair = 0; pair < 2; pair++) begin
            applyStimulus(1'b1, 32'hBFC00050, 1'b1, 1'b0, 32'h3000, 32'h0, 1'b1, 1'b0, 32'h0);
            checkGrant("t6_first", 1'b1, 32'h3000);
            tick();
            applyStimulus(1'b1, 32'hBFC00050, 1'b1, 1'b0, 32'h3000, 32'h0, 1'b1, 1'b0, 32'h0);
            checkGrant("t6_second", ~RR_MODE, RR_MODE ? 32'hBFC00050 : 32'h3000);
            tick();
            for (int i = 0; i < 2; i++) begin
                applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hEEEE0000 + i);
                checkResponse("t6_drain", 32'hEEEE0000 + i);
                tick();
            end
        end

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("end_queue_empty", exp_q.size(), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
